// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file; SCL/SDA are oversampled on the system clock.
// Supports auto-incrementing writes and reads, repeated START and NACK-terminated reads.
module i2c_target_regs #(
  parameter logic [6:0] ADDR        = 7'h20,
  parameter int         NUM_REGS    = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          SCL_in,
  input  logic          SDA_in,
  output logic          SDA_out,
  output logic          busy,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_index,
  output logic [7:0]    rd_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   sda_out_q, sda_out_d;
  logic                   busy_q, busy_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]          wr_index_q, wr_index_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             regs_d [NUM_REGS];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], SCL_in};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], SDA_in};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_out_d   = sda_out_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    // Bus conditions override any bit activity seen in the same cycle.
    if (stop_det) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      sda_out_d = 1'b1;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDR) begin
              rw_d      = shift_q[0];
              sda_out_d = 1'b0;
              state_d   = S_ADDR_ACK;
            end else begin
              state_d   = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              shift_d   = regs_q[ptr_q];
              sda_out_d = regs_q[ptr_q][7];
              state_d   = S_RDATA;
            end else begin
              sda_out_d = 1'b1;
              state_d   = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            ptr_d     = shift_q[PW-1:0];
            sda_out_d = 1'b0;
            state_d   = S_PTR_ACK;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = S_WDATA;
          end
        end
        S_WDATA: begin
          // The register is committed on the 8th rising edge so a STOP mid-byte changes nothing.
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              regs_d[ptr_q] = shift_in;
              wr_strobe_d   = 1'b1;
              wr_index_d    = ptr_q;
              wr_data_d     = shift_in;
              ptr_d         = ptr_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = S_WDATA_ACK;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_out_d = 1'b1;
              ptr_d     = ptr_q + 1'b1;
              state_d   = S_RACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_out_d = shift_q[6];
            end
          end
        end
        S_RACK: begin
          // A bit count of 9 marks an ACK seen; the next byte loads on the closing fall.
          if (scl_rise) begin
            if (sda_s) state_d = S_IGNORE;
            else       bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            shift_d   = regs_q[ptr_q];
            sda_out_d = regs_q[ptr_q][7];
            state_d   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_out_q   <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= 8'd0;
      regs_q      <= '{default: 8'h00};
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_out_q   <= sda_out_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign SDA_out   = sda_out_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = regs_q[rd_index];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C controller on a wired-AND SDA,
// a write-strobe recorder and an SDA-low watcher.
module tb_i2c_target_regs;

  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_out;
  logic       busy;
  logic       wr_strobe;
  logic [2:0] wr_index;
  logic [7:0] wr_data;
  logic [2:0] rd_index = 3'd0;
  logic [7:0] rd_data;
  logic       sda_bus;

  int checks = 0;
  int failures = 0;

  logic [10:0] strobe_q[$];
  bit          sda_low_seen = 1'b0;

  assign sda_bus = sda_ctrl & sda_out;

  i2c_target_regs #(.ADDR(7'h20), .NUM_REGS(8), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .SCL_in   (scl),
    .SDA_in   (sda_bus),
    .SDA_out  (sda_out),
    .busy     (busy),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .rd_index (rd_index),
    .rd_data  (rd_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_strobe === 1'b1) strobe_q.push_back({wr_index, wr_data});
    if (sda_out === 1'b0) sda_low_seen = 1'b1;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [2:0] i0;
    logic [2:0] i1;
  } vec_t;

  vec_t vecs[4];

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic check_strobe(input string name, input logic [2:0] idx, input logic [7:0] data);
    logic [31:0] act;
    if (strobe_q.size() > 0) act = {21'd0, strobe_q.pop_front()};
    else                     act = 32'hFFFF_FFFF;
    checkOutput(name, act, {21'd0, idx, data});
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [7:0] exp);
    rd_index = idx;
    #1;
    checkOutput(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; wait_q(1);
    scl = 1'b1;      wait_q(1);
    sda_ctrl = 1'b0; wait_q(1);
    scl = 1'b0;      wait_q(1);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; wait_q(1);
    scl = 1'b1;      wait_q(1);
    sda_ctrl = 1'b1; wait_q(1);
  endtask

  task automatic send_bit(input logic b);
    sda_ctrl = b; wait_q(1);
    scl = 1'b1;   wait_q(2);
    scl = 1'b0;   wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_ctrl = 1'b1; wait_q(1);
    scl = 1'b1;      wait_q(1);
    ack = ~sda_bus;  wait_q(1);
    scl = 1'b0;      wait_q(1);
  endtask

  task automatic read_bits(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_ctrl = 1'b1; wait_q(1);
      scl = 1'b1;      wait_q(1);
      b[i] = sda_bus;  wait_q(1);
      scl = 1'b0;      wait_q(1);
    end
  endtask

  // One write transaction of two data bytes from a table vector.
  task automatic applyStimulus(input vec_t v, output logic [3:0] acks);
    logic a;
    i2c_start();
    write_byte(8'h40, a); acks[3] = a;
    write_byte(v.ptr, a); acks[2] = a;
    write_byte(v.d0, a);  acks[1] = a;
    write_byte(v.d1, a);  acks[0] = a;
    i2c_stop();
  endtask

  initial begin
    logic       a;
    logic [3:0] acks;
    logic [7:0] b0, b1;

    vecs[0] = '{8'h00, 8'h12, 8'h34, 3'd0, 3'd1};
    vecs[1] = '{8'h06, 8'hFE, 8'h01, 3'd6, 3'd7};
    vecs[2] = '{8'hF7, 8'h9C, 8'hC9, 3'd7, 3'd0};
    vecs[3] = '{8'h2A, 8'h00, 8'hFF, 3'd2, 3'd3};

    repeat (4) @(negedge clock);
    checkOutput("reset_sda_out", {31'd0, sda_out}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    checkOutput("reset_wr_index", {29'd0, wr_index}, 32'd0);
    checkOutput("reset_wr_data", {24'd0, wr_data}, 32'd0);
    check_reg("reset_reg0", 3'd0, 8'h00);
    reset = 1'b0;
    wait_q(1);

    // Pointer write then two data bytes.
    i2c_start();
    write_byte(8'h40, a); checkOutput("t1_ack_addr", {31'd0, a}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h03, a); checkOutput("t1_ack_ptr", {31'd0, a}, 32'd1);
    write_byte(8'hA5, a); checkOutput("t1_ack_d0", {31'd0, a}, 32'd1);
    write_byte(8'h5A, a); checkOutput("t1_ack_d1", {31'd0, a}, 32'd1);
    i2c_stop();
    checkOutput("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check_strobe("t1_strobe0", 3'd3, 8'hA5);
    check_strobe("t1_strobe1", 3'd4, 8'h5A);
    check_reg("t1_reg3", 3'd3, 8'hA5);
    check_reg("t1_reg4", 3'd4, 8'h5A);

    // Pointer write, repeated START, read two bytes ending in NACK.
    i2c_start();
    write_byte(8'h40, a); checkOutput("t2_ack_addr_w", {31'd0, a}, 32'd1);
    write_byte(8'h03, a); checkOutput("t2_ack_ptr", {31'd0, a}, 32'd1);
    i2c_start();
    write_byte(8'h41, a); checkOutput("t2_ack_addr_r", {31'd0, a}, 32'd1);
    read_bits(b0);
    send_bit(1'b0);
    read_bits(b1);
    sda_low_seen = 1'b0;
    send_bit(1'b1);
    i2c_stop();
    checkOutput("t2_rd0", {24'd0, b0}, 32'h0000_00A5);
    checkOutput("t2_rd1", {24'd0, b1}, 32'h0000_005A);
    checkOutput("t2_sda_low_after_nack", {31'd0, sda_low_seen}, 32'd0);
    checkOutput("t2_no_strobe", strobe_q.size(), 32'd0);

    // Wrong address is ignored, then the right address still works.
    sda_low_seen = 1'b0;
    i2c_start();
    write_byte(8'h42, a); checkOutput("t3_nack_addr", {31'd0, a}, 32'd0);
    write_byte(8'h11, a); checkOutput("t3_nack_data", {31'd0, a}, 32'd0);
    i2c_stop();
    checkOutput("t3_sda_low_seen", {31'd0, sda_low_seen}, 32'd0);
    checkOutput("t3_no_strobe", strobe_q.size(), 32'd0);
    i2c_start();
    write_byte(8'h40, a); checkOutput("t3_ack_after", {31'd0, a}, 32'd1);
    write_byte(8'h00, a);
    i2c_stop();

    // Pointer masked to 3 bits and wrapping past the last register.
    i2c_start();
    write_byte(8'h40, a);
    write_byte(8'h0F, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a);
    write_byte(8'h33, a); checkOutput("t4_ack_last", {31'd0, a}, 32'd1);
    i2c_stop();
    check_strobe("t4_strobe0", 3'd7, 8'h11);
    check_strobe("t4_strobe1", 3'd0, 8'h22);
    check_strobe("t4_strobe2", 3'd1, 8'h33);
    check_reg("t4_reg7", 3'd7, 8'h11);
    check_reg("t4_reg0", 3'd0, 8'h22);
    check_reg("t4_reg1", 3'd1, 8'h33);

    // Reset during the 5th bit of a data byte (0x5A, that bit is 1).
    rd_index = 3'd3;
    i2c_start();
    write_byte(8'h40, a);
    write_byte(8'h03, a);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sda_ctrl = 1'b1; wait_q(1);
    scl = 1'b1;      wait_q(1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t5_sda_out", {31'd0, sda_out}, 32'd1);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    check_reg("t5_reg3_cleared", 3'd3, 8'h00);
    check_reg("t5_reg7_cleared", 3'd7, 8'h00);
    reset = 1'b0;
    wait_q(1);
    scl = 1'b0; wait_q(1);
    i2c_stop();
    checkOutput("t5_no_strobe", strobe_q.size(), 32'd0);
    i2c_start();
    write_byte(8'h40, a); checkOutput("t5_ack_addr", {31'd0, a}, 32'd1);
    write_byte(8'h02, a); checkOutput("t5_ack_ptr", {31'd0, a}, 32'd1);
    write_byte(8'h77, a); checkOutput("t5_ack_data", {31'd0, a}, 32'd1);
    i2c_stop();
    check_strobe("t5_strobe", 3'd2, 8'h77);
    check_reg("t5_reg2", 3'd2, 8'h77);

    // STOP in the middle of a data byte.
    i2c_start();
    write_byte(8'h40, a);
    write_byte(8'h05, a);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    checkOutput("t6_busy_mid", {31'd0, busy}, 32'd1);
    i2c_stop();
    checkOutput("t6_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("t6_no_strobe", strobe_q.size(), 32'd0);
    check_reg("t6_reg5", 3'd5, 8'h00);

    // Table-driven write transactions.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], acks);
      checkOutput($sformatf("vec%0d_acks", i), {28'd0, acks}, 32'h0000_000F);
      check_strobe($sformatf("vec%0d_strobe0", i), vecs[i].i0, vecs[i].d0);
      check_strobe($sformatf("vec%0d_strobe1", i), vecs[i].i1, vecs[i].d1);
      check_reg($sformatf("vec%0d_reg0", i), vecs[i].i0, vecs[i].d0);
      check_reg($sformatf("vec%0d_reg1", i), vecs[i].i1, vecs[i].d1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
